// File: rtl/ahb_timer.sv
// AHB-Lite slave timer: prescaled 32-bit counter with compare match,
// optional auto-reload and a level interrupt.
module ahb_timer #(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic        hresp,
   output logic        irq
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                  state, state_nxt;
   logic [2:0]              addr_q;
   logic                    write_q;
   logic                    accept, legal;
   logic                    wr, wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;

   logic [2:0]              ctrl;
   logic [PRESCALE_W-1:0]   prescale, presc;
   logic [31:0]             count, compare;
   logic                    match;
   logic                    tick, hit;

   logic                    unused_bits;
   assign unused_bits = ^{hburst, htrans[0], haddr[31:5], haddr[1:0]};

   assign accept = hsel & htrans[1] & hready;
   assign legal  = (haddr[4:2] <= 3'd4) && (hsize == 3'b010);

   // The legality flag lives in the state: DATA for legal beats, ERR1 otherwise.
   assign hready = (state != ST_ERR1);
   assign hresp  = (state == ST_ERR1) || (state == ST_ERR2);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q  <= haddr[4:2];
            write_q <= hwrite;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ERR1: state_nxt = ST_ERR2;
         default: begin
            if (accept) state_nxt = legal ? ST_DATA : ST_ERR1;
            else        state_nxt = ST_IDLE;
         end
      endcase
   end

   assign wr          = (state == ST_DATA) && write_q;
   assign wr_ctrl     = wr && (addr_q == 3'd0);
   assign wr_prescale = wr && (addr_q == 3'd1);
   assign wr_count    = wr && (addr_q == 3'd2);
   assign wr_compare  = wr && (addr_q == 3'd3);
   assign wr_status   = wr && (addr_q == 3'd4);

   assign tick = ctrl[0] && (presc == prescale);
   assign hit  = tick && (count == compare);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ctrl     <= '0;
         prescale <= '0;
         presc    <= '0;
         count    <= '0;
         compare  <= '1;
         match    <= 1'b0;
      end else begin
         if (wr_ctrl)     ctrl     <= hwdata[2:0];
         if (wr_prescale) prescale <= hwdata[PRESCALE_W-1:0];
         if (wr_compare)  compare  <= hwdata;

         if (wr_prescale || (wr_ctrl && !ctrl[0] && hwdata[0])) presc <= '0;
         else if (tick)                                          presc <= '0;
         else if (ctrl[0])                                       presc <= presc + PRESCALE_W'(1);

         // A bus write to COUNT takes priority over the tick increment.
         if (wr_count)  count <= hwdata;
         else if (tick) count <= (hit && ctrl[2]) ? '0 : count + 32'd1;

         if (hit)                         match <= 1'b1;
         else if (wr_status && hwdata[0]) match <= 1'b0;
      end
   end

   always_comb begin
      hrdata = '0;
      if ((state == ST_DATA) && !write_q) begin
         case (addr_q)
            3'd0:    hrdata = {29'd0, ctrl};
            3'd1:    hrdata = 32'(prescale);
            3'd2:    hrdata = count;
            3'd3:    hrdata = compare;
            3'd4:    hrdata = {31'd0, match};
            default: hrdata = '0;
         endcase
      end
   end

   assign irq = match & ctrl[1];

endmodule

// File: tb/tb_ahb_timer.sv
// Randomized and directed bench for ahb_timer against a tick-counting
// reference model of the register file and timer.
module tb_ahb_timer;
   localparam int unsigned PW = 16;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        hsel = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'b010;
   logic [2:0]  hburst = 3'b000;
   logic [31:0] hwdata = '0;
   logic [31:0] hrdata;
   logic        hready, hresp, irq;

   int n_tests = 0;
   int n_fail  = 0;

   ahb_timer #(.PRESCALE_W(PW)) dut (
      .clk(clk), .nrst(nrst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hrdata(hrdata), .hready(hready), .hresp(hresp), .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference model: prescaler advanced in bulk, COUNT stepped per elapsed tick.
   logic [2:0]        m_ctrl;
   longint unsigned   m_presc, m_prescale;
   logic [31:0]       m_count, m_compare;
   logic              m_match;

   function automatic void m_reset();
      m_ctrl = '0; m_presc = 0; m_prescale = 0;
      m_count = '0; m_compare = '1; m_match = 1'b0;
   endfunction

   function automatic void m_run(input int unsigned n);
      longint unsigned period, ticks;
      if (!m_ctrl[0]) return;
      period  = m_prescale + 1;
      ticks   = (m_presc + n) / period;
      m_presc = (m_presc + n) % period;
      for (longint unsigned t = 0; t < ticks; t++) begin
         if (m_count == m_compare) begin
            m_match = 1'b1;
            m_count = m_ctrl[2] ? 32'd0 : m_count + 32'd1;
         end else begin
            m_count = m_count + 32'd1;
         end
      end
   endfunction

   function automatic void m_commit(input logic [2:0] a, input logic [31:0] d);
      logic set_now, was_en;
      set_now = m_ctrl[0] && (m_presc == m_prescale) && (m_count == m_compare);
      was_en  = m_ctrl[0];
      m_run(1);
      case (a)
         3'd0: begin if (!was_en && d[0]) m_presc = 0; m_ctrl = d[2:0]; end
         3'd1: begin m_prescale = longint'(d[PW-1:0]); m_presc = 0; end
         3'd2: m_count = d;
         3'd3: m_compare = d;
         3'd4: if (d[0] && !set_now) m_match = 1'b0;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return {29'd0, m_ctrl};
         3'd1:    return m_prescale[31:0];
         3'd2:    return m_count;
         3'd3:    return m_compare;
         3'd4:    return {31'd0, m_match};
         default: return 32'd0;
      endcase
   endfunction

   // Bus tasks start and end 1 time unit after a rising edge.
   task automatic idle_drive();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'b010;
   endtask

   task automatic step();
      @(posedge clk); #1; m_run(1);
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = addr; hsize = 3'b010;
      step();
      idle_drive(); hwdata = data;
      @(posedge clk); #1; m_commit(addr[4:2], data);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] d, output logic [31:0] e,
                           output logic i_o, output logic i_e, output logic ok);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = addr; hsize = 3'b010;
      step();
      idle_drive();
      e = m_read(addr[4:2]); i_e = m_match & m_ctrl[1];
      @(negedge clk);
      d = hrdata; i_o = irq; ok = (hready === 1'b1) && (hresp === 1'b0);
      @(posedge clk); #1; m_run(1);
   endtask

   task automatic bus_err(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          output logic [3:0] obs);
      hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
      step();
      idle_drive(); hwdata = 32'hFFFF_FFFF;
      @(negedge clk); obs[3:2] = {hready, hresp};
      @(posedge clk); #1; m_run(1);
      @(negedge clk); obs[1:0] = {hready, hresp};
      @(posedge clk); #1; m_run(1);
   endtask

   task automatic test_reset();
      logic [31:0] d, e; logic io, ie, ok;
      #3;
      n_tests++;
      if ({hready, hresp, irq} !== 3'b100 || hrdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs ready/resp/irq=%b hrdata=%h want 100 00000000", {hready, hresp, irq}, hrdata);
      end
      @(posedge clk); #1; nrst = 1'b1; m_reset(); idle_drive();
      for (int i = 0; i < 5; i++) begin
         bus_read(32'(i * 4), d, e, io, ie, ok);
         n_tests++;
         if (d !== e || !ok) begin
            n_fail++; $display("FAIL reset_reg%0d got %h ok=%b want %h", i, d, ok, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0C; hsize = 3'b010;
      step();
      hwdata = 32'h1234_5678; hwrite = 1'b0;
      @(negedge clk);
      n_tests++;
      if (hready !== 1'b1 || hresp !== 1'b0) begin
         n_fail++; $display("FAIL b2b_write_phase ready=%b resp=%b want 1 0", hready, hresp);
      end
      @(posedge clk); #1; m_commit(3'd3, 32'h1234_5678); idle_drive();
      @(negedge clk);
      n_tests++;
      if (hrdata !== 32'h1234_5678 || hrdata !== m_read(3'd3) || hready !== 1'b1 || hresp !== 1'b0) begin
         n_fail++; $display("FAIL b2b_read got %h ready=%b resp=%b want 12345678 1 0", hrdata, hready, hresp);
      end
      @(posedge clk); #1; m_run(1);
   endtask

   task automatic test_prescale_match();
      logic [31:0] d, e; logic io, ie, ok, seen_irq;
      bus_write(32'h00, 32'd0);
      bus_write(32'h04, 32'd3);
      bus_write(32'h0C, 32'd2);
      bus_write(32'h08, 32'd0);
      bus_write(32'h10, 32'd1);
      bus_write(32'h00, 32'd7);
      seen_irq = 1'b0;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h08; hsize = 3'b010;
      for (int i = 0; i < 16; i++) begin
         step();
         if (i == 15) idle_drive();
         e = m_read(3'd2); ie = m_match & m_ctrl[1];
         @(negedge clk);
         if (irq === 1'b1) seen_irq = 1'b1;
         n_tests++;
         if (hrdata !== e || irq !== ie || hready !== 1'b1) begin
            n_fail++; $display("FAIL psc_count beat%0d got %h irq=%b want %h irq=%b", i, hrdata, irq, e, ie);
         end
      end
      @(posedge clk); #1; m_run(1);
      n_tests++;
      if (seen_irq !== 1'b1) begin
         n_fail++; $display("FAIL psc_irq_seen got %b want 1", seen_irq);
      end
      bus_read(32'h10, d, e, io, ie, ok);
      n_tests++;
      if (d !== 32'd1 || d !== e || io !== 1'b1) begin
         n_fail++; $display("FAIL psc_status got %h irq=%b want 00000001 irq=1", d, io);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] d, e; logic io, ie, ok;
      bus_write(32'h00, 32'd0);
      bus_write(32'h0C, 32'd5);
      bus_write(32'h04, 32'd0);
      bus_write(32'h08, 32'hFFFF_FFFF);
      bus_write(32'h10, 32'd1);
      bus_write(32'h00, 32'd1);
      bus_read(32'h08, d, e, io, ie, ok);
      n_tests++;
      if (d !== 32'd0 || d !== e) begin
         n_fail++; $display("FAIL wrap_count got %h want 00000000", d);
      end
      bus_read(32'h10, d, e, io, ie, ok);
      n_tests++;
      if (d !== 32'd0 || d !== e) begin
         n_fail++; $display("FAIL wrap_nomatch got %h want 00000000", d);
      end
      bus_write(32'h00, 32'd0);
      bus_write(32'h08, 32'hFFFF_FFFF);
      bus_write(32'h0C, 32'hFFFF_FFFF);
      bus_write(32'h10, 32'd1);
      bus_write(32'h00, 32'd1);
      bus_read(32'h08, d, e, io, ie, ok);
      n_tests++;
      if (d !== 32'd0 || d !== e) begin
         n_fail++; $display("FAIL wrap_count_match got %h want 00000000", d);
      end
      bus_read(32'h10, d, e, io, ie, ok);
      n_tests++;
      if (d !== 32'd1 || d !== e) begin
         n_fail++; $display("FAIL wrap_match got %h want 00000001", d);
      end
   endtask

   task automatic test_error();
      logic [31:0] d, e; logic io, ie, ok; logic [3:0] obs;
      bus_write(32'h00, 32'd0);
      bus_write(32'h00, 32'd2);
      bus_err(32'h14, 1'b0, 3'b010, obs);
      n_tests++;
      if (obs !== 4'b0111) begin
         n_fail++; $display("FAIL err_read_0x14 ready/resp pairs=%b want 0111", obs);
      end
      bus_err(32'h00, 1'b1, 3'b001, obs);
      n_tests++;
      if (obs !== 4'b0111) begin
         n_fail++; $display("FAIL err_half_write ready/resp pairs=%b want 0111", obs);
      end
      bus_err(32'h18, 1'b1, 3'b010, obs);
      n_tests++;
      if (obs !== 4'b0111) begin
         n_fail++; $display("FAIL err_write_0x18 ready/resp pairs=%b want 0111", obs);
      end
      bus_read(32'h00, d, e, io, ie, ok);
      n_tests++;
      if (d !== 32'd2 || d !== e || !ok) begin
         n_fail++; $display("FAIL err_ctrl_kept got %h ok=%b want 00000002", d, ok);
      end
   endtask

   task automatic test_w1c_race();
      logic [31:0] d, e; logic io, ie, ok;
      bus_write(32'h00, 32'd0);
      bus_write(32'h04, 32'd0);
      bus_write(32'h0C, 32'd20);
      bus_write(32'h08, 32'd19);
      bus_write(32'h10, 32'd1);
      bus_write(32'h00, 32'd3);
      bus_write(32'h10, 32'd1);
      bus_read(32'h10, d, e, io, ie, ok);
      n_tests++;
      if (d !== 32'd1 || d !== e || io !== 1'b1) begin
         n_fail++; $display("FAIL w1c_race got %h irq=%b want 00000001 irq=1", d, io);
      end
      bus_write(32'h10, 32'd1);
      bus_read(32'h10, d, e, io, ie, ok);
      n_tests++;
      if (d !== 32'd0 || d !== e || io !== 1'b0) begin
         n_fail++; $display("FAIL w1c_clear got %h irq=%b want 00000000 irq=0", d, io);
      end
   endtask

   task automatic test_reset_err1();
      logic [31:0] d, e; logic io, ie, ok;
      bus_write(32'h04, 32'd2);
      bus_write(32'h0C, 32'd0);
      bus_write(32'h08, 32'd0);
      bus_write(32'h00, 32'd7);
      repeat (4) step();
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h1C; hsize = 3'b010;
      step();
      @(negedge clk);
      n_tests++;
      if (hready !== 1'b0 || hresp !== 1'b1) begin
         n_fail++; $display("FAIL rst_err1_entry ready=%b resp=%b want 0 1", hready, hresp);
      end
      #2; nrst = 1'b0; idle_drive();
      #1;
      n_tests++;
      if ({hready, hresp, irq} !== 3'b100 || hrdata !== 32'd0) begin
         n_fail++; $display("FAIL rst_async ready/resp/irq=%b hrdata=%h want 100 00000000", {hready, hresp, irq}, hrdata);
      end
      m_reset();
      @(posedge clk); #1; nrst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus_read(32'(i * 4), d, e, io, ie, ok);
         n_tests++;
         if (d !== e || !ok) begin
            n_fail++; $display("FAIL rst_reg%0d got %h ok=%b want %h", i, d, ok, e);
         end
      end
      bus_write(32'h0C, 32'hA5A5_0000);
      bus_read(32'h0C, d, e, io, ie, ok);
      n_tests++;
      if (d !== 32'hA5A5_0000 || d !== e || !ok) begin
         n_fail++; $display("FAIL rst_first_access got %h ok=%b want a5a50000", d, ok);
      end
   endtask

   task automatic test_random();
      logic [31:0] d, e; logic io, ie, ok; logic [3:0] obs;
      int unsigned op, r;
      for (int i = 0; i < 120; i++) begin
         op = $urandom_range(0, 8);
         case (op)
            0: bus_write(32'h00, $urandom);
            1: bus_write(32'h04, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3)));
            2: bus_write(32'h08, 32'($urandom_range(0, 12)));
            3: bus_write(32'h0C, 32'($urandom_range(0, 12)));
            4: bus_write(32'h10, $urandom);
            5, 6: begin
               r = $urandom_range(0, 4);
               bus_read(32'(r * 4), d, e, io, ie, ok);
               n_tests++;
               if (d !== e || io !== ie || !ok) begin
                  n_fail++; $display("FAIL rand_read%0d reg%0d got %h irq=%b ok=%b want %h irq=%b", i, r, d, io, ok, e, ie);
               end
            end
            7: repeat ($urandom_range(1, 6)) step();
            default: begin
               bus_err(32'(4 * $urandom_range(5, 7)), 1'($urandom_range(0, 1)), 3'b010, obs);
               n_tests++;
               if (obs !== 4'b0111) begin
                  n_fail++; $display("FAIL rand_err%0d ready/resp pairs=%b want 0111", i, obs);
               end
            end
         endcase
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_back_to_back();
      test_prescale_match();
      test_wrap();
      test_error();
      test_w1c_race();
      test_random();
      test_reset_err1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete within time limit");
      $fatal(1);
   end

endmodule

// File: doc/ahb_timer.md
AHB_TIMER -- requirements
Module: ahb_timer

Interface
REQ-001 Parameter: PRESCALE_W, 16, width of the PRESCALE register and prescaler counter (1..32).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 nrst  input  1  reset, asynchronous and active-low.
REQ-004 hsel  input  1  slave select from the AHB multiplexor.
REQ-005 haddr  input  32  transfer address; only bits [4:2] are decoded.
REQ-006 htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-007 hwrite  input  1  1 = write transfer.
REQ-008 hsize  input  3  transfer size; only 3'b010 (word) is legal.
REQ-009 hburst  input  3  burst type; ignored, every beat is decoded independently.
REQ-010 hwdata  input  32  write data, valid in the data phase.
REQ-011 hrdata  output  32  read data, valid in the data phase.
REQ-012 hready  output  1  transfer done / slave ready for the next address phase.
REQ-013 hresp  output  1  0 = OKAY, 1 = ERROR.
REQ-014 irq  output  1  level interrupt = STATUS.MATCH & CTRL.IRQ_EN.

Function
REQ-015 Address phase accepted when hsel=1, htrans[1]=1 and hready=1; the block registers haddr[4:2], hwrite and a legality flag for the data phase.
REQ-016 Register map: 0x00 CTRL (bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD); 0x04 PRESCALE; 0x08 COUNT; 0x0C COMPARE; 0x10 STATUS (bit0 MATCH, write-1-to-clear). Unused bits read 0 and ignore writes.
REQ-017 Legal transfers get zero-wait OKAY: hready=1, hresp=0 in the data phase.
REQ-018 Writes commit on the clock edge ending the data phase, using hwdata.
REQ-019 Reads drive hrdata combinationally during the data phase from the current register values; hrdata=0 outside read data phases.
REQ-020 Illegal transfers (offset above 0x10, or hsize != 3'b010) get a two-cycle ERROR: cycle 1 hready=0/hresp=1, cycle 2 hready=1/hresp=1. No register is modified.
REQ-021 IDLE/BUSY or hsel=0 gives an OKAY response with no register effect.
REQ-022 FSM states IDLE, DATA, ERR1, ERR2. IDLE->DATA on a legal accept; IDLE->ERR1 on an illegal accept. DATA stays DATA on a legal accept, goes to ERR1 on an illegal accept, otherwise returns to IDLE. ERR1->ERR2 always. ERR2 goes to DATA or ERR1 on an accept, otherwise to IDLE.
REQ-023 While EN=1, the prescaler increments each cycle. When prescaler==PRESCALE it wraps to 0 and a tick fires; PRESCALE=0 gives a tick every cycle.
REQ-024 On a tick: if COUNT==COMPARE, set MATCH and load COUNT with 0 when AUTO_RELOAD=1, or COUNT+1 otherwise. If COUNT!=COMPARE, load COUNT+1. COUNT wraps 0xFFFFFFFF->0.
REQ-025 EN=0 freezes the prescaler and COUNT. Writing EN 0->1 clears the prescaler to 0.
REQ-026 A bus write to COUNT in the same cycle as a tick wins over the increment. A write to PRESCALE clears the prescaler.
REQ-027 A MATCH set and a W1C clear in the same cycle: the set wins, MATCH=1.
REQ-028 irq is combinational from registered state and carries no extra latency beyond MATCH.

Reset
REQ-029 Asynchronous nrst=0 immediately forces: FSM=IDLE, hready=1, hresp=0, hrdata=0, irq=0, CTRL=0, PRESCALE=0, COUNT=0, COMPARE=0xFFFFFFFF, STATUS=0, prescaler=0.
REQ-030 Reset asserted mid-transfer (including ERR1) aborts the transfer; the first accept after release is decoded normally.

Verification
REQ-031 Write 0x12345678 to 0x0C, then read 0x0C -> hrdata=0x12345678, hresp=0, hready=1 every cycle, back-to-back with no wait states.
REQ-032 PRESCALE=3, COMPARE=2, CTRL=0x7 -> COUNT steps 0,1,2 every 4 cycles; MATCH=1 and irq=1 at the tick where COUNT==2; COUNT then reads 0.
REQ-033 AUTO_RELOAD=0, COUNT preset 0xFFFFFFFF, PRESCALE=0, EN=1 -> COUNT=0 after one tick; no MATCH unless COMPARE=0xFFFFFFFF.
REQ-034 Read from 0x14, then a halfword write to 0x00 -> each gets hready 0 then 1 with hresp=1 for both cycles; CTRL is unchanged.
REQ-035 W1C of STATUS on the same edge a match fires -> MATCH stays 1. A W1C one cycle later -> MATCH=0 and irq=0.
REQ-036 Assert nrst during ERR1 -> hready=1, hresp=0 and all registers at reset values without waiting for a clock edge.
